// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter/sequencer for the data memory: one access per
// IDLE -> ACCESS -> RESP pass, fixed 2-cycle grant-to-done latency.
module dm_arbiter #(
  parameter int MEM_BYTES = 128
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_done,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_done,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  output logic        dm_w,
  output logic        dm_r,
  input  logic [31:0] dm_rdata,
  output logic [1:0]  dbg_state
);

  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_ACCESS = 2'd1;
  localparam logic [1:0]  ST_RESP   = 2'd2;
  localparam logic [31:0] ADDR_MAX  = 32'(MEM_BYTES - 4);

  logic [1:0]  state;
  logic        last_ptr;
  logic        lat_we;
  logic        lat_err;
  logic        lat_owner;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] rdata_q;

  logic        idle, access, resp;
  logic        any_req, pick1;
  logic        sel_we, sel_err;
  logic [31:0] sel_addr, sel_wdata;

  assign idle   = (state == ST_IDLE);
  assign access = (state == ST_ACCESS);
  assign resp   = (state == ST_RESP);

  // Handshake: req is a level held by the master; the request is taken in the
  // IDLE cycle where gnt=1, and a req still high in a later IDLE is a new one.
  always_comb begin
    any_req   = m0_req | m1_req;
    pick1     = (m0_req & m1_req) ? ~last_ptr : m1_req;
    sel_we    = pick1 ? m1_we    : m0_we;
    sel_addr  = pick1 ? m1_addr  : m0_addr;
    sel_wdata = pick1 ? m1_wdata : m0_wdata;
    sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr > ADDR_MAX);
  end

  assign m0_gnt = rst_n & idle & any_req & ~pick1;
  assign m1_gnt = rst_n & idle & any_req &  pick1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      last_ptr  <= 1'b1;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_owner <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_req) begin
            lat_we    <= sel_we;
            lat_err   <= sel_err;
            lat_owner <= pick1;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            state     <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          rdata_q <= (!lat_we && !lat_err) ? dm_rdata : '0;
          state   <= ST_RESP;
        end
        ST_RESP: begin
          last_ptr <= lat_owner;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Strobes derive only from state, so an async reset drops them at once.
  assign dm_addr  = access ? lat_addr  : '0;
  assign dm_wdata = access ? lat_wdata : '0;
  assign dm_w     = access &  lat_we & ~lat_err;
  assign dm_r     = access & ~lat_we & ~lat_err;

  assign m0_done  = resp & ~lat_owner;
  assign m1_done  = resp &  lat_owner;
  assign m0_rdata = m0_done ? rdata_q : '0;
  assign m1_rdata = m1_done ? rdata_q : '0;
  assign m0_err   = m0_done & lat_err;
  assign m1_err   = m1_done & lat_err;

  assign dbg_state = state;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: vector table of single accesses plus
// hand-written reset, tie, coherence and back-to-back sequences.
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic        dm_w, dm_r;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mem [32] = '{default: 32'h0};

  always #5 clk = ~clk;

  always @(posedge clk) if (dm_w) mem[dm_addr[6:2]] <= dm_wdata;
  assign dm_rdata = dm_r ? mem[dm_addr[6:2]] : 32'h0;

  dm_arbiter #(.MEM_BYTES(128)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_w(dm_w), .dm_r(dm_r),
    .dm_rdata(dm_rdata), .dbg_state(dbg_state)
  );

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic p, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p) begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end else begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end
  endtask

  task automatic drop_req(input logic p);
    if (p) m1_req = 1'b0;
    else   m0_req = 1'b0;
  endtask

  function automatic logic gnt_of(input logic p);
    return p ? m1_gnt : m0_gnt;
  endfunction
  function automatic logic done_of(input logic p);
    return p ? m1_done : m0_done;
  endfunction
  function automatic logic err_of(input logic p);
    return p ? m1_err : m0_err;
  endfunction
  function automatic logic [31:0] rdata_of(input logic p);
    return p ? m1_rdata : m0_rdata;
  endfunction

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"},   {30'd0, m1_gnt, m0_gnt}, 32'd0);
    check({tag, "_done"},  {30'd0, m1_done, m0_done}, 32'd0);
    check({tag, "_err"},   {30'd0, m1_err, m0_err}, 32'd0);
    check({tag, "_rdata"}, m0_rdata | m1_rdata, 32'd0);
    check({tag, "_strobe"}, {30'd0, dm_w, dm_r}, 32'd0);
    check({tag, "_dm_bus"}, dm_addr | dm_wdata, 32'd0);
  endtask

  // One isolated access; entry and exit are just after a rising edge in IDLE.
  task automatic single(input logic p, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic exp_err,
                        input logic [31:0] exp_rdata, input string tag);
    drive(p, 1'b1, we, addr, wdata);
    @(negedge clk);
    check({tag, "_gnt"}, {31'd0, gnt_of(p)}, 32'd1);
    check({tag, "_other_gnt"}, {31'd0, gnt_of(~p)}, 32'd0);
    step();
    drop_req(p);
    @(negedge clk);
    check({tag, "_dm_w"}, {31'd0, dm_w}, {31'd0, we & ~exp_err});
    check({tag, "_dm_r"}, {31'd0, dm_r}, {31'd0, ~we & ~exp_err});
    check({tag, "_dm_addr"}, dm_addr, addr);
    step();
    @(negedge clk);
    check({tag, "_done"}, {31'd0, done_of(p)}, 32'd1);
    check({tag, "_other_done"}, {31'd0, done_of(~p)}, 32'd0);
    check({tag, "_err"}, {31'd0, err_of(p)}, {31'd0, exp_err});
    check({tag, "_rdata"}, rdata_of(p), exp_rdata);
    step();
  endtask

  logic [31:0] b2b_addr [4];
  logic [31:0] b2b_exp  [4];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h20, 32'hDEADBEEF, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 1'b0, 32'h20, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 1'b1, 32'h22, 32'h55555555, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 1'b0, 32'h20, 32'h0,        1'b0, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 1'b0, 32'h80, 32'h0,        1'b1, 32'h0};
    vecs[5]  = '{1'b1, 1'b1, 32'h7C, 32'hCAFEF00D, 1'b0, 32'h0};
    vecs[6]  = '{1'b0, 1'b0, 32'h7C, 32'h0,        1'b0, 32'hCAFEF00D};
    vecs[7]  = '{1'b1, 1'b0, 32'h00, 32'h0,        1'b0, 32'h0};
    vecs[8]  = '{1'b0, 1'b0, 32'hFFFFFFFC, 32'h0,  1'b1, 32'h0};
    vecs[9]  = '{1'b1, 1'b1, 32'h04, 32'h11112222, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 1'b0, 32'h04, 32'h0,        1'b0, 32'h11112222};

    b2b_addr = '{32'h20, 32'h7C, 32'h04, 32'h00};
    b2b_exp  = '{32'hDEADBEEF, 32'h12345678, 32'h11112222, 32'h0};

    // Reset and idle state
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check("reset_state", {30'd0, dbg_state}, 32'd0);
    rst_n = 1'b1;
    step();

    // Vector table
    for (int i = 0; i < 11; i++)
      single(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
             vecs[i].exp_err, vecs[i].exp_rdata, $sformatf("vec%0d", i));

    // Reset during the ACCESS cycle of a write to 0x10
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hAAAA5555);
    @(negedge clk);
    check("rst_mid_gnt", {31'd0, m0_gnt}, 32'd1);
    step();
    drop_req(1'b0);
    @(negedge clk);
    check("rst_mid_dm_w_before", {31'd0, dm_w}, 32'd1);
    #1 rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    step();
    @(negedge clk);
    check("rst_mid_no_done", {30'd0, m1_done, m0_done}, 32'd0);
    check("rst_mid_mem_0x10", mem[4], 32'h0);
    #1 rst_n = 1'b1;
    step();

    // Both held after reset: port 0 first, then alternate
    drive(1'b0, 1'b1, 1'b0, 32'h00, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h04, 32'h0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("tie%0d_m0_gnt", k), {31'd0, m0_gnt}, {31'd0, (k % 2) == 0});
      check($sformatf("tie%0d_m1_gnt", k), {31'd0, m1_gnt}, {31'd0, (k % 2) == 1});
      step();
      @(negedge clk);
      check($sformatf("tie%0d_access_gnt", k), {30'd0, m1_gnt, m0_gnt}, 32'd0);
      step();
      @(negedge clk);
      check($sformatf("tie%0d_m0_done", k), {31'd0, m0_done}, {31'd0, (k % 2) == 0});
      check($sformatf("tie%0d_m1_done", k), {31'd0, m1_done}, {31'd0, (k % 2) == 1});
      check($sformatf("tie%0d_m1_rdata", k), m1_rdata, ((k % 2) == 1) ? 32'h11112222 : 32'h0);
      step();
    end
    drop_req(1'b0);
    drop_req(1'b1);

    // Make port 0 the last owner, then tie: port 1 write wins, port 0 reads it
    single(1'b0, 1'b0, 32'h00, 32'h0, 1'b0, 32'h0, "pre_coh");
    drive(1'b1, 1'b1, 1'b1, 32'h7C, 32'h12345678);
    drive(1'b0, 1'b1, 1'b0, 32'h7C, 32'h0);
    @(negedge clk);
    check("coh_m1_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd2);
    step();
    drop_req(1'b1);
    step();
    @(negedge clk);
    check("coh_m1_done", {30'd0, m1_done, m1_err}, 32'd2);
    step();
    @(negedge clk);
    check("coh_m0_gnt", {30'd0, m1_gnt, m0_gnt}, 32'd1);
    step();
    drop_req(1'b0);
    step();
    @(negedge clk);
    check("coh_m0_done", {31'd0, m0_done}, 32'd1);
    check("coh_m0_rdata", m0_rdata, 32'h12345678);
    step();

    // Port 0 holds req through four reads
    drive(1'b0, 1'b1, 1'b0, b2b_addr[0], 32'h0);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check($sformatf("b2b%0d_m0_gnt", c), {31'd0, m0_gnt}, {31'd0, (c % 3) == 0});
      check($sformatf("b2b%0d_m1", c), {30'd0, m1_gnt, m1_done}, 32'd0);
      check($sformatf("b2b%0d_m0_done", c), {31'd0, m0_done}, {31'd0, (c % 3) == 2});
      if ((c % 3) == 2)
        check($sformatf("b2b%0d_rdata", c), m0_rdata, b2b_exp[c / 3]);
      step();
      if ((c % 3) == 0 && (c / 3) < 3) m0_addr = b2b_addr[c / 3 + 1];
    end
    drop_req(1'b0);
    @(negedge clk);
    check("final_idle", {30'd0, dbg_state}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
